// File: rtl/game_pkg.sv
// Shared definitions for the game control FSM and datapath debug logic.
package game_pkg;

  // Control FSM state encoding
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_INIT   = 4'd1,
    S_DRAW   = 4'd2,
    S_IDLE   = 4'd3,
    S_UP     = 4'd4,
    S_DOWN   = 4'd5,
    S_LEFT   = 4'd6,
    S_RIGHT  = 4'd7,
    S_ATTACK = 4'd8
  } state_t;

  // Command line ordering on the control bus to the datapath
  localparam int unsigned NUM_CMDS   = 8;
  localparam int unsigned CMD_INIT   = 0;
  localparam int unsigned CMD_IDLE   = 1;
  localparam int unsigned CMD_ATTACK = 2;
  localparam int unsigned CMD_UP     = 3;
  localparam int unsigned CMD_DOWN   = 4;
  localparam int unsigned CMD_LEFT   = 5;
  localparam int unsigned CMD_RIGHT  = 6;
  localparam int unsigned CMD_DRAW   = 7;

  // Button bit positions inside the synchronizer vector
  localparam int unsigned NUM_BTNS   = 5;
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_ATTACK = 4;

  typedef logic [NUM_CMDS-1:0] cmd_t;

  // One-hot command word asserted while the FSM sits in a given state
  function automatic cmd_t cmd_of(state_t s);
    cmd_t c;
    c = '0;
    case (s)
      S_INIT:   c[CMD_INIT]   = 1'b1;
      S_DRAW:   c[CMD_DRAW]   = 1'b1;
      S_IDLE:   c[CMD_IDLE]   = 1'b1;
      S_UP:     c[CMD_UP]     = 1'b1;
      S_DOWN:   c[CMD_DOWN]   = 1'b1;
      S_LEFT:   c[CMD_LEFT]   = 1'b1;
      S_RIGHT:  c[CMD_RIGHT]  = 1'b1;
      S_ATTACK: c[CMD_ATTACK] = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Free-running rate divider: one-cycle tick every FRAME_DIV clocks.
module frame_tick #(
  parameter int unsigned FRAME_DIV = 833_333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tick;

  assign w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
  assign tick       = r_tick;

  // Counter wraps at FRAME_DIV-1; tick is registered so it is high exactly while count == LAST
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= (LAST == '0);
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == LAST);
    end
  end

endmodule

// File: rtl/game_control.sv
// Game control FSM: turns synchronized buttons into one-hot datapath commands per frame.
module game_control
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV     = 833_333,
  parameter int unsigned ATTACK_FRAMES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_attack,
  input  logic draw_done,
  output logic init,
  output logic idle,
  output logic attack,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic draw
);

  localparam int unsigned ATK_W = $clog2(ATTACK_FRAMES + 1);

  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] r_sync1;
  logic [NUM_BTNS-1:0] r_sync2;
  logic                w_tick;
  logic                w_up;
  logic                w_down;
  logic                w_left;
  logic                w_right;
  logic                w_atk;

  state_t              r_state;
  cmd_t                r_cmd;
  logic                r_tick_pending;
  logic                r_atk_armed;
  logic [ATK_W-1:0]    r_atk_cnt;

  assign w_btn_raw = {btn_attack, btn_right, btn_left, btn_down, btn_up};
  assign w_up      = r_sync2[BTN_UP];
  assign w_down    = r_sync2[BTN_DOWN];
  assign w_left    = r_sync2[BTN_LEFT];
  assign w_right   = r_sync2[BTN_RIGHT];
  assign w_atk     = r_sync2[BTN_ATTACK];

  frame_tick #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Control FSM with its frame bookkeeping; r_cmd always tracks the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_RESET;
      r_cmd          <= '0;
      r_tick_pending <= 1'b0;
      r_atk_cnt      <= '0;
      r_atk_armed    <= 1'b1;
    end else begin
      if (!w_atk) r_atk_armed <= 1'b1;
      if (w_tick) r_tick_pending <= 1'b1;

      case (r_state)
        S_RESET: begin
          r_state <= S_INIT;
          r_cmd   <= cmd_of(S_INIT);
        end
        S_INIT, S_UP, S_DOWN, S_LEFT, S_RIGHT: begin
          r_state <= S_DRAW;
          r_cmd   <= cmd_of(S_DRAW);
        end
        S_DRAW: begin
          if (draw_done) begin
            r_state <= S_IDLE;
            r_cmd   <= cmd_of(S_IDLE);
          end
        end
        S_IDLE: begin
          if (r_tick_pending) begin
            // A tick landing on the service cycle keeps the flag set
            if (!w_tick) r_tick_pending <= 1'b0;
            if (w_atk && r_atk_armed) begin
              r_state     <= S_ATTACK;
              r_cmd       <= cmd_of(S_ATTACK);
              r_atk_armed <= 1'b0;
              r_atk_cnt   <= ATK_W'(ATTACK_FRAMES);
            end else if (w_up) begin
              r_state <= S_UP;
              r_cmd   <= cmd_of(S_UP);
            end else if (w_down) begin
              r_state <= S_DOWN;
              r_cmd   <= cmd_of(S_DOWN);
            end else if (w_left) begin
              r_state <= S_LEFT;
              r_cmd   <= cmd_of(S_LEFT);
            end else if (w_right) begin
              r_state <= S_RIGHT;
              r_cmd   <= cmd_of(S_RIGHT);
            end
          end
        end
        S_ATTACK: begin
          if (r_atk_cnt == '0) begin
            r_state <= S_DRAW;
            r_cmd   <= cmd_of(S_DRAW);
          end else if (w_tick) begin
            r_atk_cnt <= r_atk_cnt - ATK_W'(1);
          end
        end
        default: begin
          r_state <= S_RESET;
          r_cmd   <= '0;
        end
      endcase
    end
  end

  assign init   = r_cmd[CMD_INIT];
  assign idle   = r_cmd[CMD_IDLE];
  assign attack = r_cmd[CMD_ATTACK];
  assign up     = r_cmd[CMD_UP];
  assign down   = r_cmd[CMD_DOWN];
  assign left   = r_cmd[CMD_LEFT];
  assign right  = r_cmd[CMD_RIGHT];
  assign draw   = r_cmd[CMD_DRAW];

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with FRAME_DIV=4, ATTACK_FRAMES=2 and a 3-cycle datapath model.
module tb_game_control;

  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_INIT  = 8'h01;
  localparam logic [7:0] O_IDLE  = 8'h02;
  localparam logic [7:0] O_ATK   = 8'h04;
  localparam logic [7:0] O_UP    = 8'h08;
  localparam logic [7:0] O_RIGHT = 8'h40;
  localparam logic [7:0] O_DRAW  = 8'h80;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_down, btn_left, btn_right, btn_attack;
  logic draw_done = 1'b0;
  logic init, idle, attack, up, down, left, right, draw;
  logic [7:0] outs;
  logic [7:0] got;
  logic dp_en;
  logic started = 1'b0;
  int   dcnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  game_control #(
    .FRAME_DIV     (4),
    .ATTACK_FRAMES (2)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .draw_done  (draw_done),
    .init       (init),
    .idle       (idle),
    .attack     (attack),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .draw       (draw)
  );

  assign outs = {draw, right, left, down, up, attack, idle, init};

  // Datapath model: draw_done is seen by the FSM on the 3rd edge after draw rises
  always @(posedge clk) begin
    if (draw) dcnt <= dcnt + 1;
    else      dcnt <= 0;
    draw_done <= dp_en && draw && (dcnt >= 1);
  end

  // At most one command line high in any cycle
  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      assert ($countones(outs) <= 1) n_pass++;
      else $error("FAIL onehot: observed %b required at most one bit set", outs);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Step until a command other than idle/draw appears, or the budget runs out
  task automatic wait_cmd(input int budget, output logic [7:0] obs);
    obs = outs;
    for (int i = 0; i < budget; i++) begin
      step();
      obs = outs;
      if (obs != O_IDLE && obs != O_DRAW && obs != O_NONE) break;
    end
  endtask

  task automatic draw_then_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      chk(tag, outs, O_DRAW);
    end
    step();
    chk(tag, outs, O_IDLE);
  endtask

  task automatic init_seq(input string tag);
    step();
    chk(tag, outs, O_INIT);
    draw_then_idle(tag);
  endtask

  initial begin
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
    dp_en = 1'b1;
    repeat (3) step();
    started = 1'b1;
    chk("reset_outs", outs, O_NONE);

    // Reset release: init, draw x3, idle
    reset = 1'b0;
    init_seq("release_seq");

    // No buttons: idle every cycle
    for (int i = 0; i < 20; i++) begin
      step();
      chk("quiet_idle", outs, O_IDLE);
    end

    // Held up: repeated up pulses each followed by draw
    btn_up = 1'b1;
    wait_cmd(20, got);
    chk("up_first", got, O_UP);
    draw_then_idle("up_first_draw");
    wait_cmd(20, got);
    chk("up_second", got, O_UP);
    btn_left = 1'b1;
    wait_cmd(20, got);
    chk("diag_first", got, O_UP);
    wait_cmd(20, got);
    chk("diag_second", got, O_UP);
    btn_up = 1'b0;
    btn_left = 1'b0;
    repeat (12) step();
    chk("up_release_idle", outs, O_IDLE);

    // Held attack: two frames of attack (8 cycles from a steady idle), then draw, then no repeat
    btn_attack = 1'b1;
    wait_cmd(20, got);
    chk("atk_start", got, O_ATK);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("atk_hold", outs, O_ATK);
    end
    draw_then_idle("atk_draw");
    for (int i = 0; i < 16; i++) begin
      step();
      chk("atk_no_repeat", outs, O_IDLE);
    end
    btn_attack = 1'b0;
    repeat (4) step();
    btn_attack = 1'b1;
    wait_cmd(20, got);
    chk("atk_rearmed", got, O_ATK);
    btn_attack = 1'b0;
    repeat (14) step();
    chk("atk_rearm_idle", outs, O_IDLE);

    // Stalled draw: right held during a long draw is served right after the first idle
    dp_en = 1'b0;
    btn_up = 1'b1;
    wait_cmd(20, got);
    chk("stall_up", got, O_UP);
    btn_up = 1'b0;
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_draw", outs, O_DRAW);
    end
    dp_en = 1'b1;
    step();
    chk("stall_done_draw", outs, O_DRAW);
    step();
    chk("stall_idle", outs, O_IDLE);
    step();
    chk("pending_right", outs, O_RIGHT);
    btn_right = 1'b0;
    draw_then_idle("right_draw");

    // Reset during attack
    repeat (12) step();
    btn_attack = 1'b1;
    wait_cmd(20, got);
    chk("atk_before_rst", got, O_ATK);
    repeat (2) step();
    btn_attack = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_mid_atk", outs, O_NONE);
    reset = 1'b0;
    init_seq("rst_atk_seq");

    // Reset during draw
    repeat (8) step();
    btn_up = 1'b1;
    wait_cmd(20, got);
    chk("up_before_rst", got, O_UP);
    btn_up = 1'b0;
    step();
    chk("draw_before_rst", outs, O_DRAW);
    reset = 1'b1;
    step();
    chk("rst_mid_draw", outs, O_NONE);
    reset = 1'b0;
    init_seq("rst_draw_seq");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
